// File: rtl/nn_pkg.sv
// Shared defaults, score type and FSM state encoding for the argmax classifier stage.
package nn_pkg;

  localparam int WIDTH_DEF    = 16;
  localparam int FRAC_DEF     = 8;
  localparam int OUT_SIZE_DEF = 2;
  localparam int BATCH_DEF    = 2;

  typedef logic signed [WIDTH_DEF-1:0] score_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } argmax_state_t;

  // Index/tag fields keep at least one bit so single-entry configurations stay legal.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/softmax_argmax_seq_if.sv
// Input vector and output result channels of softmax_argmax_seq.
// A transfer happens in a cycle where valid and ready are both high; the producer keeps
// its payload stable while valid is high and ready is low. ARGMAX_CONF_EN adds out_val/out_low_conf.
interface softmax_argmax_seq_if #(
  parameter int OUT_SIZE = nn_pkg::OUT_SIZE_DEF,
  parameter int WIDTH    = nn_pkg::WIDTH_DEF,
  parameter int BATCH    = nn_pkg::BATCH_DEF
);
  localparam int IDX_W = nn_pkg::clog2_min1(OUT_SIZE);
  localparam int TAG_W = nn_pkg::clog2_min1(BATCH);

  logic                           in_valid;
  logic                           in_ready;
  logic [OUT_SIZE-1:0][WIDTH-1:0] in_vec;
  logic                           out_valid;
  logic                           out_ready;
  logic [IDX_W-1:0]               out_idx;
  logic [TAG_W-1:0]               out_tag;
  logic                           out_last;
`ifdef ARGMAX_CONF_EN
  logic signed [WIDTH-1:0]        out_val;
  logic                           out_low_conf;

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_tag, out_last, out_val, out_low_conf
  );
  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_tag, out_last, out_val, out_low_conf
  );
`else
  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_tag, out_last
  );
  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_tag, out_last
  );
`endif

endinterface

// File: rtl/argmax_cmp.sv
// Combinational compare-and-select of (value, index) pairs; the candidate wins only when
// strictly greater, so an ascending scan keeps the lowest index on ties.
module argmax_cmp #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 1
) (
  input  logic signed [WIDTH-1:0] cur_val_i,
  input  logic        [IDX_W-1:0] cur_idx_i,
  input  logic signed [WIDTH-1:0] cand_val_i,
  input  logic        [IDX_W-1:0] cand_idx_i,
  output logic signed [WIDTH-1:0] sel_val_o,
  output logic        [IDX_W-1:0] sel_idx_o
);

  logic take;

  assign take      = cand_val_i > cur_val_i;
  assign sel_val_o = take ? cand_val_i : cur_val_i;
  assign sel_idx_o = take ? cand_idx_i : cur_idx_i;

endmodule

// File: rtl/softmax_argmax_seq.sv
// Sequential argmax over a softmax score vector: one comparison per cycle, result held until
// consumed, tagged with its position in the batch. Define ARGMAX_CONF_EN for out_val/out_low_conf.
module softmax_argmax_seq
  import nn_pkg::*;
#(
  parameter int                      OUT_SIZE    = OUT_SIZE_DEF,
  parameter int                      WIDTH       = WIDTH_DEF,
  parameter int                      FRAC        = FRAC_DEF,
  parameter int                      BATCH       = BATCH_DEF,
  parameter logic signed [WIDTH-1:0] CONF_THRESH = 16'sh0080
) (
  input  logic          clk,
  input  logic          rst,
  softmax_argmax_seq_if.slave bus,
  output argmax_state_t dbg_state_o
);

  localparam int               IDX_W    = clog2_min1(OUT_SIZE);
  localparam int               TAG_W    = clog2_min1(BATCH);
  localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(OUT_SIZE - 1);
  localparam logic [TAG_W-1:0] LAST_TAG = TAG_W'(BATCH - 1);

  if (FRAC >= WIDTH || $bits(CONF_THRESH) != WIDTH) begin : g_cfg_err
    $error("softmax_argmax_seq: FRAC must be below WIDTH");
  end

  argmax_state_t                  state_q, state_d;
  logic [OUT_SIZE-1:0][WIDTH-1:0] buf_q, buf_d;
  logic signed [WIDTH-1:0]        max_q, max_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [IDX_W-1:0]               ptr_q, ptr_d;
  logic [TAG_W-1:0]               tag_q, tag_d;

  logic signed [WIDTH-1:0]        cand_val;
  logic signed [WIDTH-1:0]        sel_val;
  logic [IDX_W-1:0]               sel_idx;
  logic                           in_ready, out_valid, out_last;
  logic [IDX_W-1:0]               out_idx;
  logic [TAG_W-1:0]               out_tag;
  logic                           in_fire, out_fire;

  assign cand_val = buf_q[ptr_q];

  argmax_cmp #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_cmp (
    .cur_val_i  (max_q),
    .cur_idx_i  (idx_q),
    .cand_val_i (cand_val),
    .cand_idx_i (ptr_q),
    .sel_val_o  (sel_val),
    .sel_idx_o  (sel_idx)
  );

  assign in_fire  = in_ready & bus.in_valid;
  assign out_fire = out_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (in_fire) state_d = (OUT_SIZE == 1) ? ST_HOLD : ST_SCAN;
      ST_SCAN: if (ptr_q == LAST_PTR) state_d = ST_HOLD;
      ST_HOLD: if (out_fire) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are forced to their reset values for the whole time rst is high,
  // including the first cycle before the state register has been cleared.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_idx   = '0;
    out_tag   = '0;
    out_last  = 1'b0;
    if (!rst) begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_HOLD);
      out_idx   = idx_q;
      out_tag   = tag_q;
      out_last  = (tag_q == LAST_TAG);
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_idx   = out_idx;
  assign bus.out_tag   = out_tag;
  assign bus.out_last  = out_last;
  assign dbg_state_o   = state_q;

`ifdef ARGMAX_CONF_EN
  logic signed [WIDTH-1:0] out_val;
  logic                    out_low_conf;

  always_comb begin
    out_val      = '0;
    out_low_conf = 1'b0;
    if (!rst) begin
      out_val      = max_q;
      out_low_conf = (max_q < CONF_THRESH);
    end
  end

  assign bus.out_val      = out_val;
  assign bus.out_low_conf = out_low_conf;
`endif

  always_comb begin
    buf_d = buf_q;
    max_d = max_q;
    idx_d = idx_q;
    ptr_d = ptr_q;
    tag_d = tag_q;
    if (in_fire) begin
      buf_d = bus.in_vec;
      max_d = bus.in_vec[0];
      idx_d = '0;
      ptr_d = IDX_W'(1);
    end
    if (state_q == ST_SCAN) begin
      max_d = sel_val;
      idx_d = sel_idx;
      if (ptr_q != LAST_PTR) ptr_d = ptr_q + IDX_W'(1);
    end
    if (out_fire) tag_d = (tag_q == LAST_TAG) ? '0 : tag_q + TAG_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q <= '0;
      max_q <= '0;
      idx_q <= '0;
      ptr_q <= '0;
      tag_q <= '0;
    end else begin
      buf_q <= buf_d;
      max_q <= max_d;
      idx_q <= idx_d;
      ptr_q <= ptr_d;
      tag_q <= tag_d;
    end
  end

endmodule

// File: tb/tb_softmax_argmax_seq.sv
// Bench for softmax_argmax_seq: a 2-score instance with hand-computed cases and a 4-score
// instance under random traffic, both checked every cycle against a behavioural argmax model.
module tb_softmax_argmax_seq;
  import nn_pkg::*;

  localparam int NA    = 2;
  localparam int BA    = 2;
  localparam int NB    = 4;
  localparam int BB    = 3;
  localparam int W     = 16;
  localparam int EXP_W = 24;

  logic clk   = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   cyc   = 0;
  int   checks   = 0;
  int   failures = 0;

  argmax_state_t dbg_a, dbg_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  softmax_argmax_seq_if #(.OUT_SIZE(NA), .WIDTH(W), .BATCH(BA)) bus_a ();
  softmax_argmax_seq_if #(.OUT_SIZE(NB), .WIDTH(W), .BATCH(BB)) bus_b ();

  softmax_argmax_seq #(.OUT_SIZE(NA), .WIDTH(W), .FRAC(8), .BATCH(BA)) u_dut_a (
    .clk         (clk),
    .rst         (rst_a),
    .bus         (bus_a),
    .dbg_state_o (dbg_a)
  );

  softmax_argmax_seq #(.OUT_SIZE(NB), .WIDTH(W), .FRAC(8), .BATCH(BB)) u_dut_b (
    .clk         (clk),
    .rst         (rst_b),
    .bus         (bus_b),
    .dbg_state_o (dbg_b)
  );

  // Scoreboard: expected {max value, argmax index} of the vector currently in flight per instance.
  logic [EXP_W-1:0] exp_q [2][$];
  bit               m_pend [2];
  int               m_due  [2];
  int               m_tag  [2];
  bit               m_ev   [2];
  int               m_ev_val [2];

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0080;
      1:       return 16'hFFF0;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  // One cycle of the reference: expectations follow from the handshake history only.
  task automatic model_step(input int d, input int n, input int batch, input logic r,
                            input logic iv, input int v[4], input logic ir, input logic ov,
                            input logic ordy, input int idx, input int tag, input logic last);
    string p = (d == 0) ? "a" : "b";
    logic [EXP_W-1:0] e;
    int mx;
    int mi;
    bit ev;
    m_ev[d] = 1'b0;
    if (r) begin
      chk({p, "_rst_in_ready"},  ir,   0);
      chk({p, "_rst_out_valid"}, ov,   0);
      chk({p, "_rst_out_idx"},   idx,  0);
      chk({p, "_rst_out_tag"},   tag,  0);
      chk({p, "_rst_out_last"},  last, 0);
      m_pend[d] = 1'b0;
      m_tag[d]  = 0;
      exp_q[d].delete();
      return;
    end
    ev = m_pend[d] && (cyc >= m_due[d]);
    chk({p, "_in_ready"},  ir, !m_pend[d]);
    chk({p, "_out_valid"}, ov, ev);
    if (ev) begin
      e = exp_q[d][0];
      m_ev[d]     = 1'b1;
      m_ev_val[d] = int'($signed(e[23:8]));
      chk({p, "_out_idx"},  idx,  int'(e[7:0]));
      chk({p, "_out_tag"},  tag,  m_tag[d]);
      chk({p, "_out_last"}, last, (m_tag[d] == batch - 1));
      if (ordy) begin
        void'(exp_q[d].pop_front());
        m_pend[d] = 1'b0;
        m_tag[d]  = (m_tag[d] + 1) % batch;
      end
    end else if (!m_pend[d] && iv) begin
      mx = v[0];
      for (int i = 1; i < n; i++) if (v[i] > mx) mx = v[i];
      mi = 0;
      for (int i = n - 1; i >= 0; i--) if (v[i] == mx) mi = i;
      exp_q[d].push_back({mx[15:0], mi[7:0]});
      m_pend[d] = 1'b1;
      m_due[d]  = cyc + n;
    end
  endtask

`ifdef ARGMAX_CONF_EN
  task automatic conf_check(input int d, input logic r, input int val, input logic low);
    string p = (d == 0) ? "a" : "b";
    if (r) begin
      chk({p, "_rst_out_val"},      val, 0);
      chk({p, "_rst_out_low_conf"}, low, 0);
    end else if (m_ev[d]) begin
      chk({p, "_out_val"},      val, m_ev_val[d]);
      chk({p, "_out_low_conf"}, low, (m_ev_val[d] < 128));
    end
  endtask
`endif

  always @(negedge clk) begin : compare
    int va[4];
    int vb[4];
    for (int i = 0; i < 4; i++) begin
      va[i] = 0;
      vb[i] = int'($signed(bus_b.in_vec[i]));
    end
    for (int i = 0; i < NA; i++) va[i] = int'($signed(bus_a.in_vec[i]));
    model_step(0, NA, BA, rst_a, bus_a.in_valid, va, bus_a.in_ready, bus_a.out_valid,
               bus_a.out_ready, int'(bus_a.out_idx), int'(bus_a.out_tag), bus_a.out_last);
    model_step(1, NB, BB, rst_b, bus_b.in_valid, vb, bus_b.in_ready, bus_b.out_valid,
               bus_b.out_ready, int'(bus_b.out_idx), int'(bus_b.out_tag), bus_b.out_last);
`ifdef ARGMAX_CONF_EN
    conf_check(0, rst_a, int'($signed(bus_a.out_val)), bus_a.out_low_conf);
    conf_check(1, rst_b, int'($signed(bus_b.out_val)), bus_b.out_low_conf);
`endif
  end

  // ---------------- instance A driver tasks (called at posedge + 1) ----------------
  task automatic send_a(input int s0, input int s1, output int k);
    int n = 0;
    bus_a.in_valid  = 1'b1;
    bus_a.in_vec[0] = s0[15:0];
    bus_a.in_vec[1] = s1[15:0];
    @(negedge clk);
    while (!bus_a.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("a_accept_in_time", (n < 20), 1);
    k = cyc;
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
  endtask

  task automatic wait_out_a(input int k, input int exp_idx, input int exp_tag);
    int n = 0;
    @(negedge clk);
    while (!bus_a.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("a_latency",  cyc - k, NA);
    chk("a_lit_idx",  bus_a.out_idx,  exp_idx);
    chk("a_lit_tag",  bus_a.out_tag,  exp_tag);
    chk("a_lit_last", bus_a.out_last, (exp_tag == BA - 1));
  endtask

  task automatic release_a(input int hold, input int exp_idx);
    repeat (hold) begin
      @(posedge clk); #1;
      bus_a.in_valid  = 1'($urandom_range(0, 1));
      bus_a.in_vec[0] = 16'($urandom);
      bus_a.in_vec[1] = 16'($urandom);
      @(negedge clk);
      chk("a_hold_valid",    bus_a.out_valid, 1);
      chk("a_hold_idx",      bus_a.out_idx,   exp_idx);
      chk("a_hold_in_ready", bus_a.in_ready,  0);
    end
    @(posedge clk); #1;
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus_a.out_ready = 1'b0;
    @(negedge clk);
    chk("a_drop_valid",    bus_a.out_valid, 0);
    chk("a_idle_in_ready", bus_a.in_ready,  1);
    @(posedge clk); #1;
  endtask

  task automatic run_a();
    int k;
    int n;
    int sent;
    int got;
    int tags[3];
    int lasts[3];
    bus_a.in_valid  = 1'b0;
    bus_a.in_vec    = '0;
    bus_a.out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("a_lit_rst_in_ready",  bus_a.in_ready,  0);
      chk("a_lit_rst_out_valid", bus_a.out_valid, 0);
      chk("a_lit_rst_out_tag",   bus_a.out_tag,   0);
    end
    @(posedge clk); #1;
    rst_a = 1'b0;
    @(negedge clk);
    chk("a_ready_after_rst", bus_a.in_ready, 1);
    @(posedge clk); #1;

    send_a(16'h0040, 16'h00C0, k);
    wait_out_a(k, 1, 0);
    release_a(5, 1);
    send_a(16'h0080, 16'h0080, k);
    wait_out_a(k, 0, 1);
    release_a(0, 0);
    send_a(16'hFFF0, 16'hFFE0, k);
    wait_out_a(k, 0, 0);
    release_a(2, 0);
`ifdef ARGMAX_CONF_EN
    send_a(16'h0060, 16'h0030, k);
    wait_out_a(k, 0, 1);
    chk("a_lit_val",      int'($signed(bus_a.out_val)), 32'h60);
    chk("a_lit_low_conf", bus_a.out_low_conf, 1);
    release_a(1, 0);
    send_a(16'h00E0, 16'h0020, k);
    wait_out_a(k, 0, 0);
    chk("a_lit_val",      int'($signed(bus_a.out_val)), 32'hE0);
    chk("a_lit_low_conf", bus_a.out_low_conf, 0);
    release_a(0, 0);
`endif

    // Back-to-back vectors after a fresh reset: tag/last must run 0,1,0.
    rst_a = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    sent = 0;
    got  = 0;
    n    = 0;
    bus_a.out_ready = 1'b1;
    bus_a.in_valid  = 1'b1;
    bus_a.in_vec[0] = pick();
    bus_a.in_vec[1] = pick();
    while (got < 3 && n < 60) begin
      @(negedge clk);
      if (bus_a.out_valid && got < 3) begin
        tags[got]  = int'(bus_a.out_tag);
        lasts[got] = int'(bus_a.out_last);
        got++;
      end
      if (bus_a.in_valid && bus_a.in_ready) sent++;
      @(posedge clk); #1;
      bus_a.in_valid  = (sent < 3);
      bus_a.in_vec[0] = pick();
      bus_a.in_vec[1] = pick();
      n++;
    end
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b0;
    chk("a_b2b_count", got, 3);
    for (int i = 0; i < got && i < 3; i++) begin
      chk("a_b2b_tag",  tags[i],  (i == 1));
      chk("a_b2b_last", lasts[i], (i == 1));
    end
  endtask

  // ---------------- instance B driver tasks ----------------
  task automatic rst_in_scan_b();
    int n = 0;
    bus_b.out_ready = 1'b1;
    bus_b.in_valid  = 1'b1;
    for (int j = 0; j < NB; j++) bus_b.in_vec[j] = pick();
    @(negedge clk);
    while (!bus_b.in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("b_scan_accept_in_time", (n < 30), 1);
    @(posedge clk); #1;
    bus_b.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b1;
    @(negedge clk);
    chk("b_lit_rst_out_valid", bus_b.out_valid, 0);
    chk("b_lit_rst_in_ready",  bus_b.in_ready,  0);
    chk("b_lit_rst_out_idx",   bus_b.out_idx,   0);
    chk("b_lit_rst_out_tag",   bus_b.out_tag,   0);
    @(posedge clk); #1;
    rst_b = 1'b0;
    @(negedge clk);
    chk("b_lit_ready_after_rst", bus_b.in_ready,  1);
    chk("b_lit_no_output",       bus_b.out_valid, 0);
    @(posedge clk); #1;
  endtask

  task automatic run_b();
    bus_b.in_valid  = 1'b0;
    bus_b.in_vec    = '0;
    bus_b.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_b = 1'b0;
    for (int it = 0; it < 3000; it++) begin
      if (it % 500 == 250) begin
        rst_in_scan_b();
      end else begin
        bus_b.in_valid = ($urandom_range(0, 3) != 0);
        for (int j = 0; j < NB; j++) bus_b.in_vec[j] = pick();
        bus_b.out_ready = ($urandom_range(0, 2) != 0);
        @(posedge clk); #1;
      end
    end
    bus_b.in_valid = 1'b0;
  endtask

  initial begin
    fork
      run_a();
      run_b();
    join
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
